// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, FSM states,
// ALU operations, PC source selects and the opcode class used by the FSM.
package ctrl_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Instruction class: everything the FSM needs to know about an opcode.
  typedef enum logic [2:0] {
    CLS_UNDEF = 3'd0,
    CLS_ALU   = 3'd1,
    CLS_LW    = 3'd2,
    CLS_SW    = 3'd3,
    CLS_BEQ   = 3'd4,
    CLS_BNE   = 3'd5,
    CLS_J     = 3'd6,
    CLS_HALT  = 3'd7
  } op_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder for the multi-cycle controller.
// Define CTRL_BNE_EN to decode bne (110001); otherwise it is an undefined opcode.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] alu_op,
  output logic       alu_src_b,
  output logic       ext_sel,
  output logic       reg_dst,
  output logic       db_data_src,
  output op_class_t  op_class
);

  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_b   = 1'b0;
    ext_sel     = 1'b0;
    reg_dst     = 1'b0;
    db_data_src = 1'b0;
    op_class    = CLS_UNDEF;
    case (opcode)
      OP_ADD:   begin alu_op = ALU_ADD; reg_dst = 1'b1; op_class = CLS_ALU; end
      OP_SUB:   begin alu_op = ALU_SUB; reg_dst = 1'b1; op_class = CLS_ALU; end
      OP_ADDIU: begin
        alu_op = ALU_ADD; alu_src_b = 1'b1; ext_sel = 1'b1; op_class = CLS_ALU;
      end
      OP_AND:   begin alu_op = ALU_AND; reg_dst = 1'b1; op_class = CLS_ALU; end
      OP_ANDI:  begin alu_op = ALU_AND; alu_src_b = 1'b1; op_class = CLS_ALU; end
      OP_ORI:   begin alu_op = ALU_OR;  alu_src_b = 1'b1; op_class = CLS_ALU; end
      OP_SLL:   begin alu_op = ALU_SLL; reg_dst = 1'b1; op_class = CLS_ALU; end
      OP_SLTI:  begin
        alu_op = ALU_SLT; alu_src_b = 1'b1; ext_sel = 1'b1; op_class = CLS_ALU;
      end
      OP_SW:    begin
        alu_op = ALU_ADD; alu_src_b = 1'b1; ext_sel = 1'b1; op_class = CLS_SW;
      end
      OP_LW:    begin
        alu_op = ALU_ADD; alu_src_b = 1'b1; ext_sel = 1'b1;
        db_data_src = 1'b1; op_class = CLS_LW;
      end
      OP_BEQ:   begin alu_op = ALU_SUB; ext_sel = 1'b1; op_class = CLS_BEQ; end
`ifdef CTRL_BNE_EN
      OP_BNE:   begin alu_op = ALU_SUB; ext_sel = 1'b1; op_class = CLS_BNE; end
`endif
      OP_J:     op_class = CLS_J;
      OP_HALT:  op_class = CLS_HALT;
      default:  op_class = CLS_UNDEF;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: IF/ID/EXE/MEM/WB sequencer plus
// state-qualified datapath enables. Optional bne support via CTRL_BNE_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       ExtSel,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic       RegWre,
  output logic       RegDst,
  output logic       DBDataSrc,
  output logic [2:0] state
);

  state_t    state_q;
  state_t    state_d;
  logic [2:0] dec_alu_op;
  logic       dec_alu_src_b;
  logic       dec_ext_sel;
  logic       dec_reg_dst;
  logic       dec_db_data_src;
  op_class_t  dec_class;
  logic       branch_taken;

  ctrl_decode u_decode (
    .opcode      (Opcode),
    .alu_op      (dec_alu_op),
    .alu_src_b   (dec_alu_src_b),
    .ext_sel     (dec_ext_sel),
    .reg_dst     (dec_reg_dst),
    .db_data_src (dec_db_data_src),
    .op_class    (dec_class)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (dec_class)
          CLS_J:            state_d = S_IF;
          CLS_HALT:         state_d = S_ID;
          CLS_BEQ, CLS_BNE: state_d = S_EXE_BR;
          CLS_LW, CLS_SW:   state_d = S_EXE_LS;
          CLS_ALU:          state_d = S_EXE_AL;
          default:          state_d = S_IF;
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (dec_class == CLS_LW) ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  // bne only ever appears as a class when the decoder was built with it.
  assign branch_taken = (dec_class == CLS_BNE) ? ~zero : zero;

  // Every output is held at zero while Reset is low, decode fields included.
  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = PC_NEXT;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    mWR       = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 1'b0;
    DBDataSrc = 1'b0;
    state     = 3'b000;
    if (Reset) begin
      state     = state_q;
      ExtSel    = dec_ext_sel;
      ALUSrcB   = dec_alu_src_b;
      ALUOp     = dec_alu_op;
      RegDst    = dec_reg_dst;
      DBDataSrc = dec_db_data_src;
      case (state_q)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          if (dec_class == CLS_J) begin
            PCWre = 1'b1;
            PCSrc = PC_JUMP;
          end else if (dec_class == CLS_UNDEF) begin
            PCWre = 1'b1;
          end
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          if (branch_taken) PCSrc = PC_BRANCH;
        end
        S_MEM: begin
          if (dec_class == CLS_LW) mRD = 1'b1;
          if (dec_class == CLS_SW) begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end
        end
        S_WB_AL, S_WB_LD: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction stream
// against a per-instruction cycle model; honours CTRL_BNE_EN when defined.
module tb_multicycle_ctrl;

  localparam int K_UNDEF = 0;
  localparam int K_ALU   = 1;
  localparam int K_LW    = 2;
  localparam int K_SW    = 3;
  localparam int K_BEQ   = 4;
  localparam int K_BNE   = 5;
  localparam int K_J     = 6;
  localparam int K_HALT  = 7;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Opcode = 6'b000000;
  logic       zero = 1'b0;
  logic       PCWre;
  logic [1:0] PCSrc;
  logic       IRWre;
  logic       ExtSel;
  logic       ALUSrcB;
  logic [2:0] ALUOp;
  logic       mRD;
  logic       mWR;
  logic       RegWre;
  logic       RegDst;
  logic       DBDataSrc;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  logic [5:0] known_ops [14] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000,
                                 6'b010001, 6'b010010, 6'b011000, 6'b011100,
                                 6'b100110, 6'b100111, 6'b110000, 6'b110001,
                                 6'b111000, 6'b110000};

  multicycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ExtSel(ExtSel),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .RegWre(RegWre), .RegDst(RegDst), .DBDataSrc(DBDataSrc), .state(state)
  );

  always #5 CLK = ~CLK;

  // dec = {ExtSel, ALUSrcB, ALUOp[2:0], RegDst, DBDataSrc}
  function automatic void model_decode(input logic [5:0] op, output logic [6:0] dec,
                                       output int kind);
    dec = 7'b0;
    kind = K_UNDEF;
    case (op)
      6'b000000: begin dec = 7'b0_0_000_1_0; kind = K_ALU; end
      6'b000001: begin dec = 7'b0_0_001_1_0; kind = K_ALU; end
      6'b000010: begin dec = 7'b1_1_000_0_0; kind = K_ALU; end
      6'b010000: begin dec = 7'b0_0_010_1_0; kind = K_ALU; end
      6'b010001: begin dec = 7'b0_1_010_0_0; kind = K_ALU; end
      6'b010010: begin dec = 7'b0_1_011_0_0; kind = K_ALU; end
      6'b011000: begin dec = 7'b0_0_100_1_0; kind = K_ALU; end
      6'b011100: begin dec = 7'b1_1_101_0_0; kind = K_ALU; end
      6'b100110: begin dec = 7'b1_1_000_0_0; kind = K_SW; end
      6'b100111: begin dec = 7'b1_1_000_0_1; kind = K_LW; end
      6'b110000: begin dec = 7'b1_0_001_0_0; kind = K_BEQ; end
`ifdef CTRL_BNE_EN
      6'b110001: begin dec = 7'b1_0_001_0_0; kind = K_BNE; end
`endif
      6'b111000: kind = K_J;
      6'b111111: kind = K_HALT;
      default:   kind = K_UNDEF;
    endcase
  endfunction

  function automatic int cycles_of(input int kind);
    case (kind)
      K_ALU, K_SW:   return 4;
      K_LW:          return 5;
      K_BEQ, K_BNE:  return 3;
      default:       return 2;
    endcase
  endfunction

  function automatic logic [2:0] state_at(input int kind, input int idx);
    if (idx == 0) return 3'b000;
    if (idx == 1) return 3'b001;
    if (kind == K_BEQ || kind == K_BNE) return 3'b101;
    if (kind == K_ALU) return (idx == 2) ? 3'b110 : 3'b111;
    return (idx == 2) ? 3'b010 : (idx == 3) ? 3'b011 : 3'b100;
  endfunction

  // {PCWre, PCSrc, IRWre, ExtSel, ALUSrcB, ALUOp, mRD, mWR, RegWre, RegDst, DBDataSrc, state}
  function automatic logic [16:0] expect_vec(input logic [5:0] op, input int idx, input logic z);
    logic [6:0] dec;
    int kind;
    logic last, pcwre, irwre, regwre, mrd, mwr;
    logic [1:0] pcsrc;
    model_decode(op, dec, kind);
    last   = (idx == cycles_of(kind) - 1);
    pcwre  = last && (kind != K_HALT);
    irwre  = (idx == 0);
    regwre = last && (kind == K_ALU || kind == K_LW);
    mrd    = (kind == K_LW) && (idx == 3);
    mwr    = (kind == K_SW) && (idx == 3);
    pcsrc  = 2'b00;
    if (kind == K_J && idx == 1) pcsrc = 2'b10;
    if (idx == 2 && ((kind == K_BEQ && z) || (kind == K_BNE && !z))) pcsrc = 2'b01;
    return {pcwre, pcsrc, irwre, dec[6:5], dec[4:2], mrd, mwr, regwre, dec[1:0],
            state_at(kind, idx)};
  endfunction

  function automatic logic [16:0] actual_vec();
    return {PCWre, PCSrc, IRWre, ExtSel, ALUSrcB, ALUOp, mRD, mWR, RegWre,
            RegDst, DBDataSrc, state};
  endfunction

  // Entered just after a rising edge with the FSM in sIF; leaves the same way.
  // zmode < 0 randomizes zero every cycle, otherwise zero is held at zmode.
  task automatic run_instr(input logic [5:0] op, input int zmode, input string name);
    logic [6:0] dec;
    int kind;
    logic [16:0] exp_v;
    model_decode(op, dec, kind);
    Opcode = op;
    for (int idx = 0; idx < cycles_of(kind); idx++) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge CLK);
      exp_v = expect_vec(op, idx, zero);
      checks++;
      if (actual_vec() !== exp_v) begin
        errors++;
        $display("FAIL %s op=%b cycle=%0d got=%h expected=%h", name, op, idx,
                 actual_vec(), exp_v);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #1;
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Opcode = 6'b000000;
    #12;
    checks++;
    if (actual_vec() !== 17'h0) begin
      errors++;
      $display("FAIL reset_add got=%h expected=%h", actual_vec(), 17'h0);
    end
    Opcode = 6'b100111;
    #1;
    checks++;
    if (actual_vec() !== 17'h0) begin
      errors++;
      $display("FAIL reset_lw got=%h expected=%h", actual_vec(), 17'h0);
    end
    Opcode = 6'b000000;
    release_reset();
    run_instr(6'b000000, -1, "after_reset_add");
  endtask

  task automatic test_directed();
    run_instr(6'b000000, -1, "add");
    run_instr(6'b100111, -1, "lw");
    run_instr(6'b100110, -1, "sw");
    run_instr(6'b110000, 1, "beq_taken");
    run_instr(6'b110000, 0, "beq_not_taken");
    run_instr(6'b111000, -1, "j");
    run_instr(6'b110001, 0, "op110001_z0");
    run_instr(6'b110001, 1, "op110001_z1");
    run_instr(6'b101010, -1, "undefined");
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = 6'($urandom_range(0, 62));
      end else begin
        op = known_ops[$urandom_range(0, 13)];
      end
      run_instr(op, -1, "random");
    end
  endtask

  task automatic test_mid_reset(input logic [5:0] op, input int stop_idx, input string name);
    logic [16:0] exp_v;
    Opcode = op;
    for (int idx = 0; idx <= stop_idx; idx++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge CLK);
      exp_v = expect_vec(op, idx, zero);
      checks++;
      if (actual_vec() !== exp_v) begin
        errors++;
        $display("FAIL %s_pre cycle=%0d got=%h expected=%h", name, idx, actual_vec(), exp_v);
      end
      if (idx != stop_idx) begin
        @(posedge CLK);
        #1;
      end
    end
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (actual_vec() !== 17'h0) begin
      errors++;
      $display("FAIL %s_in_reset got=%h expected=%h", name, actual_vec(), 17'h0);
    end
    release_reset();
    run_instr(6'b000001, -1, {name, "_next_sub"});
  endtask

  task automatic test_halt();
    logic [16:0] exp_v;
    Opcode = 6'b111111;
    for (int idx = 0; idx < 12; idx++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge CLK);
      exp_v = expect_vec(6'b111111, (idx == 0) ? 0 : 1, zero);
      checks++;
      if (actual_vec() !== exp_v) begin
        errors++;
        $display("FAIL halt cycle=%0d got=%h expected=%h", idx, actual_vec(), exp_v);
      end
      @(posedge CLK);
      #1;
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (state !== 3'b000 || PCWre !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset state=%b pcwre=%b expected state=000 pcwre=0", state, PCWre);
    end
    release_reset();
    run_instr(6'b100111, -1, "after_halt_lw");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mid_reset(6'b000000, 3, "reset_in_wb_al");
    test_mid_reset(6'b100110, 3, "reset_in_mem_sw");
    test_mid_reset(6'b100111, 4, "reset_in_wb_ld");
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
